// File: rtl/call_stack_ctrl.sv
// Hardware return-address stack for the call/RET path: circular array, head pointer, count, sticky errors.
// Optional build macro CALL_STACK_WRAP_EN: a push when full overwrites the oldest entry instead of being dropped.
module call_stack_ctrl #(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] ret_addr_in,
   output logic [ADDR_W-1:0] ret_addr_out,
   output logic              empty,
   output logic              full,
   output logic [CNT_W-1:0]  count,
   output logic              overflow,
   output logic              underflow,
   input  logic              clear_err
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  topIdx;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              wrEn;
   logic [PTR_W-1:0]  wrIdx;
   logic              isEmpty, isFull;

   assign topIdx  = head_q - PTR_W'(1);
   assign isEmpty = (count_q == '0);
   assign isFull  = (count_q == CNT_W'(DEPTH));

   // Next-state decode; error flags are set-dominant over clear_err.
   always_comb begin
      head_d  = head_q;
      count_d = count_q;
      wrEn    = 1'b0;
      wrIdx   = head_q;
      ovf_d   = ovf_q & ~clear_err;
      unf_d   = unf_q & ~clear_err;
      unique case ({push, pop})
         2'b10: begin
            if (!isFull) begin
               wrEn    = 1'b1;
               head_d  = head_q + PTR_W'(1);
               count_d = count_q + CNT_W'(1);
            end else begin
               ovf_d = 1'b1;
`ifdef CALL_STACK_WRAP_EN
               wrEn   = 1'b1;
               head_d = head_q + PTR_W'(1);
`endif
            end
         end
         2'b01: begin
            if (!isEmpty) begin
               head_d  = head_q - PTR_W'(1);
               count_d = count_q - CNT_W'(1);
            end else begin
               unf_d = 1'b1;
            end
         end
         2'b11: begin
            // Tail-call: replace the top in place; on an empty stack it degrades to a push.
            if (!isEmpty) begin
               wrEn  = 1'b1;
               wrIdx = topIdx;
            end else begin
               wrEn    = 1'b1;
               head_d  = head_q + PTR_W'(1);
               count_d = count_q + CNT_W'(1);
               unf_d   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         head_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Storage has no reset; a write is suppressed while reset is asserted.
   always_ff @(posedge clock) begin
      if (reset_n && wrEn) begin
         mem_q[wrIdx] <= ret_addr_in;
      end
   end

   assign ret_addr_out = isEmpty ? '0 : mem_q[topIdx];
   assign empty        = isEmpty;
   assign full         = isFull;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Scoreboard bench for call_stack_ctrl: directed vectors push hand-computed expectations, a monitor compares.
// Expectations follow the CALL_STACK_WRAP_EN build when that macro is defined.
module tb_call_stack_ctrl;

   typedef struct {
      string       name;
      logic [3:0]  cnt;
      logic [11:0] top;
      logic        emp;
      logic        ful;
      logic        ovf;
      logic        unf;
   } exp_t;

   logic        clock;
   logic        reset_n;
   logic        push;
   logic        pop;
   logic        clear_err;
   logic [11:0] ret_addr_in;
   logic [11:0] ret_addr_out;
   logic        empty;
   logic        full;
   logic [3:0]  count;
   logic        overflow;
   logic        underflow;

   exp_t expQ[$];
   int   vectorCount = 0;
   int   missCount   = 0;

   call_stack_ctrl #(.ADDR_W(12), .DEPTH(8), .CNT_W(4)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .push         (push),
      .pop          (pop),
      .ret_addr_in  (ret_addr_in),
      .ret_addr_out (ret_addr_out),
      .empty        (empty),
      .full         (full),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow),
      .clear_err    (clear_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drive one cycle of inputs, then queue the state expected after that rising edge.
   task automatic applyStimulus(input string nm, input logic rn, input logic p, input logic po,
                                input logic clr, input logic [11:0] a, input logic [3:0] c,
                                input logic [11:0] t, input logic ov, input logic un);
      exp_t e;
      @(negedge clock);
      reset_n     = rn;
      push        = p;
      pop         = po;
      clear_err   = clr;
      ret_addr_in = a;
      @(posedge clock);
      #1;
      e.name = nm;
      e.cnt  = c;
      e.top  = t;
      e.emp  = (c == 4'd0);
      e.ful  = (c == 4'd8);
      e.ovf  = ov;
      e.unf  = un;
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      vectorCount++;
      if (count !== e.cnt || ret_addr_out !== e.top || empty !== e.emp || full !== e.ful ||
          overflow !== e.ovf || underflow !== e.unf) begin
         missCount++;
         $display("[TB] FAIL %s: got cnt=%0d top=%h empty=%b full=%b ovf=%b unf=%b, want cnt=%0d top=%h empty=%b full=%b ovf=%b unf=%b",
                  e.name, count, ret_addr_out, empty, full, overflow, underflow,
                  e.cnt, e.top, e.emp, e.ful, e.ovf, e.unf);
      end
   endtask

   // Monitor: outputs depend only on registered state, so the falling edge is a stable sample point.
   always @(negedge clock) begin
      if (expQ.size() > 0) begin
         checkOutput(expQ.pop_front());
      end
   end

   initial begin
      logic [11:0] topExp;
      reset_n     = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      clear_err   = 1'b0;
      ret_addr_in = '0;

      applyStimulus("reset0", 0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0);
      applyStimulus("reset1", 0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0);
      applyStimulus("pre1",   1, 1, 0, 0, 12'h111, 1, 12'h111, 0, 0);
      applyStimulus("pre2",   1, 1, 0, 0, 12'h222, 2, 12'h222, 0, 0);
      applyStimulus("pre3",   1, 1, 0, 0, 12'h333, 3, 12'h333, 0, 0);
      applyStimulus("rstPush",0, 1, 0, 0, 12'h444, 0, 12'h000, 0, 0);
      applyStimulus("rstPop", 0, 0, 1, 0, 12'h000, 0, 12'h000, 0, 0);

      applyStimulus("push101", 1, 1, 0, 0, 12'h101, 1, 12'h101, 0, 0);
      applyStimulus("push202", 1, 1, 0, 0, 12'h202, 2, 12'h202, 0, 0);
      applyStimulus("push303", 1, 1, 0, 0, 12'h303, 3, 12'h303, 0, 0);
      applyStimulus("popA",    1, 0, 1, 0, 12'h000, 2, 12'h202, 0, 0);
      applyStimulus("popB",    1, 0, 1, 0, 12'h000, 1, 12'h101, 0, 0);
      applyStimulus("popC",    1, 0, 1, 0, 12'h000, 0, 12'h000, 0, 0);

      applyStimulus("tc101",   1, 1, 0, 0, 12'h101, 1, 12'h101, 0, 0);
      applyStimulus("tc202",   1, 1, 0, 0, 12'h202, 2, 12'h202, 0, 0);
      applyStimulus("tailCall",1, 1, 1, 0, 12'h7AB, 2, 12'h7AB, 0, 0);
      applyStimulus("tcPop1",  1, 0, 1, 0, 12'h000, 1, 12'h101, 0, 0);
      applyStimulus("tcPop2",  1, 0, 1, 0, 12'h000, 0, 12'h000, 0, 0);

      applyStimulus("unfPop",   1, 0, 1, 0, 12'h000, 0, 12'h000, 0, 1);
      applyStimulus("unfHold",  1, 0, 0, 0, 12'h000, 0, 12'h000, 0, 1);
      applyStimulus("unfClr",   1, 0, 0, 1, 12'h000, 0, 12'h000, 0, 0);
      applyStimulus("unfPop2",  1, 0, 1, 0, 12'h000, 0, 12'h000, 0, 1);
      applyStimulus("unfSetWin",1, 0, 1, 1, 12'h000, 0, 12'h000, 0, 1);
      applyStimulus("unfClr2",  1, 0, 0, 1, 12'h000, 0, 12'h000, 0, 0);

      applyStimulus("ppEmpty",  1, 1, 1, 0, 12'h055, 1, 12'h055, 0, 1);
      applyStimulus("ppDrain",  1, 0, 1, 1, 12'h000, 0, 12'h000, 0, 0);

      for (int i = 1; i <= 8; i++) begin
         topExp = 12'(i * 16);
         applyStimulus($sformatf("fill%0d", i), 1, 1, 0, 0, topExp, 4'(i), topExp, 0, 0);
      end
`ifdef CALL_STACK_WRAP_EN
      applyStimulus("pushFull", 1, 1, 0, 0, 12'h090, 8, 12'h090, 1, 0);
      applyStimulus("fullHold", 1, 0, 0, 0, 12'h000, 8, 12'h090, 1, 0);
      for (int k = 1; k <= 7; k++) begin
         topExp = 12'(12'h090 - k * 16);
         applyStimulus($sformatf("drain%0d", k), 1, 0, 1, 0, 12'h000, 4'(8 - k), topExp, 1, 0);
      end
`else
      applyStimulus("pushFull", 1, 1, 0, 0, 12'h090, 8, 12'h080, 1, 0);
      applyStimulus("fullHold", 1, 0, 0, 0, 12'h000, 8, 12'h080, 1, 0);
      for (int k = 1; k <= 7; k++) begin
         topExp = 12'(12'h080 - k * 16);
         applyStimulus($sformatf("drain%0d", k), 1, 0, 1, 0, 12'h000, 4'(8 - k), topExp, 1, 0);
      end
`endif
      applyStimulus("drain8",   1, 0, 1, 0, 12'h000, 0, 12'h000, 1, 0);
      applyStimulus("bothErr",  1, 0, 1, 0, 12'h000, 0, 12'h000, 1, 1);
      applyStimulus("clrBoth",  1, 0, 0, 1, 12'h000, 0, 12'h000, 0, 0);

      for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
         @(posedge clock);
      end
      if (expQ.size() > 0) begin
         missCount++;
         $display("[TB] FAIL drain: got %0d unchecked vectors, want 0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
